// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch front end: pulls 64-byte lines from Sysbus into a circular
// byte buffer and presents a 15-byte decode window with its RIP.
module fetch_unit #(
    parameter int unsigned BUF_BYTES    = 128,
    parameter int unsigned LINE_BYTES   = 64,
    parameter int unsigned WINDOW_BYTES = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 entry,
    input  logic                        redirect,
    input  logic [63:0]                 redirect_rip,
    output logic                        reqcyc,
    output logic [63:0]                 req,
    output logic [12:0]                 reqtag,
    input  logic                        reqack,
    input  logic                        respcyc,
    input  logic [63:0]                 resp,
    output logic                        respack,
    output logic                        dec_valid,
    output logic [8*WINDOW_BYTES-1:0]   dec_bytes,
    output logic [63:0]                 dec_rip,
    input  logic [3:0]                  dec_consume
);

    localparam int unsigned PTR_W  = $clog2(BUF_BYTES);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned BEATS  = LINE_BYTES / 8;
    localparam int unsigned BEAT_W = $clog2(BEATS);

    // Sysbus tag: READ (1'b1), MEMORY (4'b0001), zero low byte
    localparam logic [12:0] REQ_TAG = {1'b1, 4'b0001, 8'h00};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACTIVE,
        DRAIN
    } state_t;

    state_t              state;
    logic [7:0]          fifo_mem [BUF_BYTES];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [OCC_W-1:0]    occupancy;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [63:0]         fetch_line;
    logic [OFF_W-1:0]    skip;

    logic [OFF_W-1:0]    beat_base;
    logic [OFF_W-1:0]    skip_diff;
    logic [3:0]          drop;
    logic [3:0]          wr_cnt;
    logic                beat_in;
    logic                do_write;
    logic                last_beat;
    logic [3:0]          written;
    logic [3:0]          consumed;
    logic [OCC_W-1:0]    occ_next;

    assign respack = respcyc;

    // Per-beat write count: leading bytes below the entry offset are dropped
    always_comb begin
        beat_base = OFF_W'({beat_cnt, 3'b000});
        skip_diff = skip - beat_base;
        drop      = 4'd0;
        if (skip > beat_base) begin
            drop = (skip_diff >= OFF_W'(8)) ? 4'd8 : 4'(skip_diff);
        end
        wr_cnt    = 4'd8 - drop;
        beat_in   = respcyc && ((state == WAIT) || (state == ACTIVE));
        do_write  = beat_in && !redirect;
        last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
        written   = do_write ? wr_cnt : 4'd0;
        consumed  = redirect ? 4'd0 : dec_consume;
        occ_next  = redirect ? '0
                             : occupancy + OCC_W'(written) - OCC_W'(consumed);
    end

    // Decode window read straight from the buffer, wrapping at BUF_BYTES
    always_comb begin
        dec_bytes = '0;
        for (int i = 0; i < int'(WINDOW_BYTES); i++) begin
            dec_bytes[8*i +: 8] = fifo_mem[head + PTR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) >= drop) begin
                    fifo_mem[tail + PTR_W'(i) - PTR_W'(drop)] <= resp[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            reqcyc     <= 1'b0;
            req        <= '0;
            reqtag     <= '0;
            head       <= '0;
            tail       <= '0;
            occupancy  <= '0;
            dec_valid  <= 1'b0;
            beat_cnt   <= '0;
            fetch_line <= entry & ~64'(LINE_BYTES - 1);
            skip       <= entry[OFF_W-1:0];
            dec_rip    <= entry;
        end else begin
            occupancy <= occ_next;
            dec_valid <= (occ_next >= OCC_W'(WINDOW_BYTES));

            // Beats of the outstanding line are counted even while draining
            if (respcyc && (state != IDLE)) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end

            if (redirect) begin
                head       <= '0;
                tail       <= '0;
                fetch_line <= redirect_rip & ~64'(LINE_BYTES - 1);
                skip       <= redirect_rip[OFF_W-1:0];
                dec_rip    <= redirect_rip;
            end else begin
                head    <= head + PTR_W'(dec_consume);
                dec_rip <= dec_rip + 64'(dec_consume);
                if (do_write) begin
                    tail <= tail + PTR_W'(wr_cnt);
                end
                if (beat_in && last_beat) begin
                    skip       <= '0;
                    fetch_line <= fetch_line + 64'(LINE_BYTES);
                end
            end

            case (state)
                IDLE: begin
                    if (reqcyc) begin
                        if (reqack) begin
                            reqcyc <= 1'b0;
                            state  <= redirect ? DRAIN : WAIT;
                        end else if (redirect) begin
                            reqcyc <= 1'b0;
                        end
                    end else if (!redirect &&
                                 occupancy <= OCC_W'(BUF_BYTES - LINE_BYTES)) begin
                        reqcyc <= 1'b1;
                        req    <= fetch_line;
                        reqtag <= REQ_TAG;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state <= DRAIN;
                    end else if (respcyc) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (respcyc && last_beat) begin
                        state <= IDLE;
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (respcyc && last_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sysbus delivers the 8 beats of a line back to back
    a_resp_contiguous: assert property (@(posedge clk) disable iff (reset)
        (state == ACTIVE) |-> respcyc);

    // Decoder may only retire bytes that are actually buffered
    a_consume_legal: assert property (@(posedge clk) disable iff (reset)
        (dec_consume != 4'd0) |-> (dec_valid && (OCC_W'(dec_consume) <= occupancy)));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_unit: Sysbus line responder with a request
// scoreboard, a table of entry points, and hand-written multi-cycle sequences.
module tb_fetch_unit;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   entry;
    logic          redirect;
    logic [63:0]   redirect_rip;
    logic          reqcyc;
    logic [63:0]   req;
    logic [12:0]   reqtag;
    logic          reqack;
    logic          respcyc;
    logic [63:0]   resp;
    logic          respack;
    logic          dec_valid;
    logic [119:0]  dec_bytes;
    logic [63:0]   dec_rip;
    logic [3:0]    dec_consume;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redirect     (redirect),
        .redirect_rip (redirect_rip),
        .reqcyc       (reqcyc),
        .req          (req),
        .reqtag       (reqtag),
        .reqack       (reqack),
        .respcyc      (respcyc),
        .resp         (resp),
        .respack      (respack),
        .dec_valid    (dec_valid),
        .dec_bytes    (dec_bytes),
        .dec_rip      (dec_rip),
        .dec_consume  (dec_consume)
    );

    localparam logic [12:0] TAG_READ_MEM = 13'h1100;

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          acks_left  = 0;
    int          lines_done = 0;
    int          drv_beat   = -1;
    logic [63:0] exp_req_q [$];

    typedef struct {
        logic [63:0] entry;
        int          occ;
        bit          valid;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: every byte holds the low 8 bits of its own address
    function automatic logic [119:0] window_of(input logic [63:0] rip);
        logic [119:0] w;
        for (int i = 0; i < 15; i++) w[8*i +: 8] = 8'(rip + 64'(i));
        return w;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a, input int b);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(a + 64'(8*b + j));
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Sysbus responder: acks up to acks_left requests, 2 idle cycles, 8 beats
    initial begin : responder
        logic [63:0] line_addr;
        int          gap;
        int          beat;
        bit          pend;
        line_addr = '0;
        gap       = 0;
        beat      = 0;
        pend      = 1'b0;
        reqack    = 1'b0;
        respcyc   = 1'b0;
        resp      = '0;
        forever begin
            @(posedge clk);
            #1;
            reqack   = 1'b0;
            drv_beat = -1;
            if (pend) begin
                if (gap > 0) begin
                    gap--;
                    respcyc = 1'b0;
                end else begin
                    respcyc  = 1'b1;
                    resp     = beat_data(line_addr, beat);
                    drv_beat = beat;
                    if (beat == 7) pend = 1'b0;
                    beat++;
                end
            end else begin
                if (respcyc) lines_done++;
                respcyc = 1'b0;
                if (reqcyc && !reset && acks_left > 0) begin
                    check("req_expected", 128'(exp_req_q.size() > 0), 128'(1));
                    if (exp_req_q.size() > 0) begin
                        check("req_addr", 128'(req), 128'(exp_req_q.pop_front()));
                    end
                    check("req_tag", 128'(reqtag), 128'(TAG_READ_MEM));
                    reqack    = 1'b1;
                    line_addr = req;
                    pend      = 1'b1;
                    gap       = 2;
                    beat      = 0;
                    acks_left--;
                end
            end
        end
    end

    task automatic do_reset(input logic [63:0] e);
        reset       = 1'b1;
        entry       = e;
        redirect    = 1'b0;
        dec_consume = 4'd0;
        step();
        step();
        check("rst_reqcyc", 128'(reqcyc), 128'(0));
        check("rst_req", 128'(req), 128'(0));
        check("rst_reqtag", 128'(reqtag), 128'(0));
        check("rst_dec_valid", 128'(dec_valid), 128'(0));
        check("rst_dec_rip", 128'(dec_rip), 128'(e));
        check("rst_occupancy", 128'(dut.occupancy), 128'(0));
        reset = 1'b0;
    endtask

    task automatic wait_lines(input int target);
        int n;
        n = 0;
        while (lines_done < target && n < 400) begin
            step();
            n++;
        end
        check("line_timeout", 128'(lines_done >= target), 128'(1));
    endtask

    task automatic wait_beat(input int k);
        int n;
        n = 0;
        while (!(respcyc && drv_beat == k) && n < 200) begin
            step();
            n++;
        end
        check("beat_timeout", 128'(respcyc && drv_beat == k), 128'(1));
    endtask

    task automatic check_filled(input string tag, input int occ, input logic [63:0] rip);
        check({tag, "_occ"}, 128'(dut.occupancy), 128'(occ));
        check({tag, "_rip"}, 128'(dec_rip), 128'(rip));
        check({tag, "_valid"}, 128'(dec_valid), 128'(occ >= 15));
        if (occ >= 15) check({tag, "_window"}, 128'(dec_bytes), 128'(window_of(rip)));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          start;
        logic [63:0] exp_rip;
        bit          saw_wrap;

        vecs[0] = '{64'h0000_0000_0000_1000, 64, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_1013, 45, 1'b1};
        vecs[2] = '{64'h0000_0000_0000_1031, 15, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_1032, 14, 1'b0};
        vecs[4] = '{64'h0000_0000_0000_103F,  1, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC8, 56, 1'b1};

        reset        = 1'b1;
        entry        = '0;
        redirect     = 1'b0;
        redirect_rip = '0;
        dec_consume  = 4'd0;

        // Entry-point table: one line fetched, window and fill level checked
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].entry);
            start     = lines_done;
            acks_left = 1;
            exp_req_q.push_back(vecs[v].entry & ~64'h3F);
            step();
            check("first_reqcyc", 128'(reqcyc), 128'(1));
            check("first_req", 128'(req), 128'(vecs[v].entry & ~64'h3F));
            check("first_tag", 128'(reqtag), 128'(TAG_READ_MEM));
            check("respack", 128'(respack), 128'(respcyc));
            wait_lines(start + 1);
            repeat (3) step();
            check("tbl_valid_flag", 128'(dec_valid), 128'(vecs[v].valid));
            check_filled("tbl", vecs[v].occ, vecs[v].entry);
        end

        // Backpressure: two lines fill the buffer, third waits for space
        do_reset(64'h1000);
        start     = lines_done;
        acks_left = 2;
        exp_req_q.push_back(64'h1000);
        exp_req_q.push_back(64'h1040);
        wait_lines(start + 2);
        repeat (3) step();
        check_filled("bp_full", 128, 64'h1000);
        check("bp_no_req_full", 128'(reqcyc), 128'(0));
        for (int i = 0; i < 4; i++) begin
            dec_consume = 4'd15;
            step();
        end
        dec_consume = 4'd0;
        repeat (3) step();
        check_filled("bp_68", 68, 64'h103C);
        check("bp_no_req_68", 128'(reqcyc), 128'(0));
        dec_consume = 4'd4;
        step();
        dec_consume = 4'd0;
        check("bp_occ_64", 128'(dut.occupancy), 128'(64));
        check("bp_req_lag", 128'(reqcyc), 128'(0));
        step();
        check("bp_req_at_64", 128'(reqcyc), 128'(1));
        check("bp_req_addr", 128'(req), 128'(64'h1080));

        // Same-cycle consume of 4 and a full 8-byte beat
        do_reset(64'h1000);
        start     = lines_done;
        acks_left = 1;
        exp_req_q.push_back(64'h1000);
        wait_beat(2);
        check("sim_occ_before", 128'(dut.occupancy), 128'(16));
        check("sim_valid_before", 128'(dec_valid), 128'(1));
        dec_consume = 4'd4;
        step();
        dec_consume = 4'd0;
        check("sim_occ_after", 128'(dut.occupancy), 128'(20));
        wait_lines(start + 1);
        repeat (3) step();
        check_filled("sim_line", 60, 64'h1004);

        // Redirect coinciding with beat 3 of an active line
        do_reset(64'h1000);
        start     = lines_done;
        acks_left = 2;
        exp_req_q.push_back(64'h1000);
        exp_req_q.push_back(64'h2000);
        wait_beat(3);
        check("rd_valid_before", 128'(dec_valid), 128'(1));
        redirect     = 1'b1;
        redirect_rip = 64'h2008;
        step();
        redirect = 1'b0;
        check("rd_valid_flush", 128'(dec_valid), 128'(0));
        check("rd_occ_flush", 128'(dut.occupancy), 128'(0));
        check("rd_rip_flush", 128'(dec_rip), 128'(64'h2008));
        wait_lines(start + 2);
        repeat (3) step();
        check_filled("rd_line", 56, 64'h2008);

        // Redirect in IDLE while a request is pending without ack
        do_reset(64'h1000);
        start     = lines_done;
        acks_left = 0;
        step();
        check("ri_reqcyc", 128'(reqcyc), 128'(1));
        redirect     = 1'b1;
        redirect_rip = 64'h4000;
        step();
        redirect = 1'b0;
        check("ri_reqcyc_drop", 128'(reqcyc), 128'(0));
        check("ri_rip", 128'(dec_rip), 128'(64'h4000));
        step();
        check("ri_reqcyc_again", 128'(reqcyc), 128'(1));
        check("ri_req", 128'(req), 128'(64'h4000));
        acks_left = 1;
        exp_req_q.push_back(64'h4000);
        wait_lines(start + 1);
        repeat (3) step();
        check_filled("ri_line", 64, 64'h4000);

        // Reset asserted mid-line; remaining stray beats must be ignored
        do_reset(64'h1000);
        start     = lines_done;
        acks_left = 1;
        exp_req_q.push_back(64'h1000);
        wait_beat(3);
        reset = 1'b1;
        entry = 64'h3000;
        step();
        check("mr_reqcyc", 128'(reqcyc), 128'(0));
        check("mr_req", 128'(req), 128'(0));
        check("mr_reqtag", 128'(reqtag), 128'(0));
        check("mr_valid", 128'(dec_valid), 128'(0));
        check("mr_rip", 128'(dec_rip), 128'(64'h3000));
        check("mr_occ", 128'(dut.occupancy), 128'(0));
        step();
        reset     = 1'b0;
        acks_left = 1;
        exp_req_q.push_back(64'h3000);
        wait_lines(start + 2);
        repeat (3) step();
        check_filled("mr_line", 64, 64'h3000);

        // Streaming with 15-byte consumes; head wraps past byte 127
        do_reset(64'h1000);
        start     = lines_done;
        acks_left = 6;
        for (int i = 0; i < 6; i++) exp_req_q.push_back(64'h1000 + 64'(64 * i));
        exp_rip  = 64'h1000;
        saw_wrap = 1'b0;
        for (int c = 0; c < 800; c++) begin
            step();
            dec_consume = 4'd0;
            if (dec_valid) begin
                check("wrap_rip", 128'(dec_rip), 128'(exp_rip));
                check("wrap_window", 128'(dec_bytes), 128'(window_of(exp_rip)));
                if (exp_rip[6:0] == 7'h78) saw_wrap = 1'b1;
                dec_consume = 4'd15;
                exp_rip     = exp_rip + 64'd15;
            end else if (lines_done >= start + 6) begin
                break;
            end
        end
        dec_consume = 4'd0;
        check("wrap_lines", 128'(lines_done >= start + 6), 128'(1));
        check("wrap_seen", 128'(saw_wrap), 128'(1));
        check("wrap_final_rip", 128'(exp_rip), 128'(64'h1000 + 64'd375));
        check("req_queue_empty", 128'(exp_req_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end between Sysbus and the instruction decoder.
- Issues 64-byte line reads on Sysbus and streams the 8 response beats into a 128-byte circular byte buffer.
- Presents a 15-byte window plus its RIP to the decoder, and retires the bytes the decoder reports as consumed.
- Supports a redirect (branch/entry) that flushes the buffer and drains any in-flight line.

Parameters:
- BUF_BYTES, 128: circular buffer size in bytes; power of two.
- LINE_BYTES, 64: bytes per Sysbus read, delivered as 8 beats of 64 bits.
- WINDOW_BYTES, 15: decode window width; maximum x86 instruction length.

Ports:
- clk  in  1  core clock (bus.clk).
- reset  in  1  synchronous, active-high reset (bus.reset).
- entry  in  64  initial RIP, sampled while reset is high.
- redirect  in  1  one-cycle pulse: restart fetch at redirect_rip.
- redirect_rip  in  64  new fetch RIP.
- reqcyc  out  1  Sysbus request valid; registered.
- req  out  64  line address, always 64-byte aligned; registered.
- reqtag  out  13  {READ, MEMORY, 8'b0}; registered.
- reqack  in  1  Sysbus request accepted.
- respcyc  in  1  response beat valid.
- resp  in  64  response data; byte 0 is resp[7:0].
- respack  out  1  equals respcyc, combinationally.
- dec_valid  out  1  occupancy >= WINDOW_BYTES and not flushing.
- dec_bytes  out  120  head 15 bytes; byte i at bits [8i+7:8i]; wraps modulo BUF_BYTES.
- dec_rip  out  64  RIP of the head byte.
- dec_consume  in  4  bytes retired this cycle, 0..15.

Behaviour:
- Reset values: reqcyc=0, req=0, reqtag=0, dec_valid=0, occupancy=0, head=tail=0, state=IDLE, fetch_line=entry&~63, skip=entry[5:0], dec_rip=entry.
- State IDLE:
  - Sets reqcyc=1 next cycle if occupancy <= BUF_BYTES-LINE_BYTES and no redirect this cycle.
  - req/reqtag are held stable while reqcyc=1.
  - On reqack: reqcyc=0 next cycle, go to WAIT.
- State WAIT: first respcyc goes to ACTIVE. That beat is processed in the same cycle.
- State ACTIVE:
  - A 3-bit beat counter covers line bytes [8k, 8k+7].
  - Bytes with line offset < skip are discarded; the rest are written at tail, so 0..8 bytes per beat.
  - Tail and occupancy advance by the number of bytes written.
  - After beat 7: skip=0, fetch_line += 64, go to IDLE.
  - If respcyc drops before beat 7, raise an assertion failure.
- State DRAIN (redirect while in WAIT or ACTIVE): keep respack=respcyc and discard all beats. When the 8th beat of the outstanding line is seen, go to IDLE.
- Redirect, in any state:
  - Next cycle: head=tail=0, occupancy=0, dec_valid=0, fetch_line=redirect_rip&~63, skip=redirect_rip[5:0], dec_rip=redirect_rip.
  - Redirect wins over a same-cycle consume or beat write.
  - Redirect in IDLE with reqcyc=1 and reqack in the same cycle: go to DRAIN.
  - Redirect in IDLE with reqcyc=1 and no reqack: drop reqcyc next cycle, stay in IDLE.
- Consume:
  - head += dec_consume mod BUF_BYTES; dec_rip += dec_consume (64-bit wrap).
  - Nonzero dec_consume while dec_valid=0, or dec_consume > occupancy, raises an assertion failure.
- Same-cycle fill and consume: occupancy_next = occupancy + written − consumed. Width is 8 bits, range 0..128; never overflows because requests are gated on free space >= LINE_BYTES.
- dec_valid and dec_bytes reflect registered head/occupancy: a consume is visible the following cycle.
- Reset mid-operation: all state returns to reset values. Stray beats after reset are acknowledged and ignored, because the counter and state are IDLE.

Test Plan:
- Cold start: entry=0x1000; memory line at 0x1000 = bytes 0x00..0x3F.
  - Expect reqcyc=1, req=0x1000, tag={READ,MEMORY,0} on the first cycle after reset.
  - After 8 beats: occupancy 64, dec_valid=1, dec_bytes byte0=0x00 … byte14=0x0E, dec_rip=0x1000.
- Unaligned entry: entry=0x1013.
  - Beats 0–1 fully dropped; beat 2 writes 5 bytes.
  - After the line: occupancy 45, dec_bytes byte0=0x13, dec_rip=0x1013.
- Backpressure: dec_consume=0 throughout.
  - The second line is requested at occupancy 64 → 128.
  - No third request issued while occupancy > 64.
- Wrap-around:
  - Consume 15/cycle while lines stream.
  - The head crossing byte 127→0 yields contiguous dec_bytes (bytes 120..127, 0..6).
  - dec_rip increments by 15 each cycle.
- Redirect during ACTIVE at beat 3: redirect_rip=0x2008.
  - Remaining 4 beats discarded; dec_valid=0.
  - Next req=0x2000; after fill, dec_rip=0x2008, occupancy 56.
- Simultaneous: consume=4 and a full 8-byte beat in the same cycle → occupancy +4. Reset asserted mid-line → all outputs at reset values the next cycle.
